rf_wb_arbiter: RTL



---
 rtl/pkg_config.sv | 23 ++
 rtl/rf_wb_arbiter_hold_buf.sv | 79 +++++++
 rtl/rf_wb_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pkg_config.sv
// -----------------------------------------------------------------------------
// pkg_config
// Shared configuration for the register-file writeback path: data width,
// register count, the writeback starvation limit and the writeback request
// record type.
// -----------------------------------------------------------------------------
package pkg_config;

    localparam int DATA_WIDTH      = 32;
    localparam int NUM_REGISTER    = 32;
    localparam int AW              = $clog2(NUM_REGISTER);

    // Consecutive EX arbitration losses before EX is forced to win (1..15).
    localparam int WB_STARVE_LIMIT = 3;

    // One buffered writeback request.
    typedef struct packed {
        logic                  valid;
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage : pkg_config

// File: rtl/rf_wb_arbiter_hold_buf.sv
// -----------------------------------------------------------------------------
// wb_hold_buf
// Single-entry writeback holding buffer behind a valid/ready handshake.
// Writes addressed to x0 complete the handshake but are never stored.
//
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   valid_i       upstream request
//   ready_o       buffer can accept (empty, or being drained this cycle)
//   addr_i/data_i upstream destination register / write data
//   grant_i       arbiter selected this buffer; it drains at the next edge
//   occ_o         buffer holds a write
//   addr_o/data_o buffered destination register / write data
// -----------------------------------------------------------------------------
module wb_hold_buf
    import pkg_config::*;
#(
    parameter int DATA_WIDTH   = pkg_config::DATA_WIDTH,
    parameter int NUM_REGISTER = pkg_config::NUM_REGISTER,
    localparam int AW          = $clog2(NUM_REGISTER)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  grant_i,
    output logic                  occ_o,
    output logic [AW-1:0]         addr_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  valid_q, valid_d;
    logic [AW-1:0]         addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  accept;

    assign ready_o = !rst_i && (!valid_q || grant_i);
    assign accept  = valid_i && ready_o;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (grant_i) begin
            valid_d = 1'b0;
        end
        // A same-edge transfer refills the slot being drained; x0 is dropped.
        if (accept && (addr_i != '0)) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            data_d  = data_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    // NOTE: the payload is reset too; it is only two small registers and it
    // keeps the outputs clean during and straight after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign occ_o  = valid_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule : wb_hold_buf

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the register_file single write port between the EX stage and the
// LSU. Each requester lands in a one-entry holding buffer; a fixed-priority
// arbiter (LSU first, EX forced after STARVE_LIMIT losses) drives the port.
// Also exports a mask of registers with a buffered, not yet retired write.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   ex_valid_i/ex_ready_o        EX handshake
//   ex_rd_addr_i/ex_rd_i         EX destination register / data
//   lsu_valid_i/lsu_ready_o      LSU handshake
//   lsu_rd_addr_i/lsu_rd_i       LSU destination register / data
//   we_o/rd_addr_o/rd_o          register_file write port
//   pending_mask_o               bit r set while a write to xr is buffered
// -----------------------------------------------------------------------------
module rf_wb_arbiter
    import pkg_config::*;
#(
    parameter int DATA_WIDTH   = pkg_config::DATA_WIDTH,
    parameter int NUM_REGISTER = pkg_config::NUM_REGISTER,
    parameter int STARVE_LIMIT = pkg_config::WB_STARVE_LIMIT,
    localparam int AW          = $clog2(NUM_REGISTER)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ex_valid_i,
    output logic                    ex_ready_o,
    input  logic [AW-1:0]           ex_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]   ex_rd_i,
    input  logic                    lsu_valid_i,
    output logic                    lsu_ready_o,
    input  logic [AW-1:0]           lsu_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_rd_i,
    output logic                    we_o,
    output logic [AW-1:0]           rd_addr_o,
    output logic [DATA_WIDTH-1:0]   rd_o,
    output logic [NUM_REGISTER-1:0] pending_mask_o
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic                  ex_occ,   lsu_occ;
    logic [AW-1:0]         ex_addr,  lsu_addr;
    logic [DATA_WIDTH-1:0] ex_data,  lsu_data;
    logic                  ex_grant, lsu_grant;
    logic [3:0]            starve_cnt_q, starve_cnt_d;

    wb_hold_buf #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_REGISTER (NUM_REGISTER)
    ) u_ex_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (ex_valid_i),
        .ready_o (ex_ready_o),
        .addr_i  (ex_rd_addr_i),
        .data_i  (ex_rd_i),
        .grant_i (ex_grant),
        .occ_o   (ex_occ),
        .addr_o  (ex_addr),
        .data_o  (ex_data)
    );

    wb_hold_buf #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_REGISTER (NUM_REGISTER)
    ) u_lsu_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (lsu_valid_i),
        .ready_o (lsu_ready_o),
        .addr_i  (lsu_rd_addr_i),
        .data_i  (lsu_rd_i),
        .grant_i (lsu_grant),
        .occ_o   (lsu_occ),
        .addr_o  (lsu_addr),
        .data_o  (lsu_data)
    );

    // Arbitration. On a same-register conflict LSU always goes first so the
    // younger EX value is the one left in the register file.
    always_comb begin
        ex_grant  = 1'b0;
        lsu_grant = 1'b0;
        if (ex_occ && !lsu_occ) begin
            ex_grant = 1'b1;
        end else if (lsu_occ && !ex_occ) begin
            lsu_grant = 1'b1;
        end else if (ex_occ && lsu_occ) begin
            if (ex_addr == lsu_addr) begin
                lsu_grant = 1'b1;
            end else if (starve_cnt_q == STARVE_MAX) begin
                ex_grant = 1'b1;
            end else begin
                lsu_grant = 1'b1;
            end
        end
    end

    // Count consecutive EX losses; any EX win or empty EX buffer clears it.
    always_comb begin
        starve_cnt_d = '0;
        if (ex_occ && lsu_grant) begin
            starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? STARVE_MAX
                                                        : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Write port: winner contents, all zero when idle. Buffers clear
    // asynchronously on reset, so the port goes quiet immediately.
    always_comb begin
        we_o      = 1'b0;
        rd_addr_o = '0;
        rd_o      = '0;
        if (lsu_grant) begin
            we_o      = 1'b1;
            rd_addr_o = lsu_addr;
            rd_o      = lsu_data;
        end else if (ex_grant) begin
            we_o      = 1'b1;
            rd_addr_o = ex_addr;
            rd_o      = ex_data;
        end
    end

    // Buffers never hold x0, and bit 0 is skipped so it stays constant zero.
    always_comb begin
        pending_mask_o = '0;
        for (int r = 1; r < NUM_REGISTER; r++) begin
            pending_mask_o[r] = (ex_occ  && (ex_addr  == AW'(r))) ||
                                (lsu_occ && (lsu_addr == AW'(r)));
        end
    end

endmodule : rf_wb_arbiter
